jbi_trans_timeout_tracker: RTL and testbench

Parametrised transaction-timeout tracker for outstanding JBus requests. Each of 2^ID_W transaction IDs gets an aging timer. The timer is armed when a request issues and cleared when its completion returns. An ID that collects AGE_LIMIT shared ticks without completing is flagged as timed out and reported through a one-entry, pop-acknowledged error port. This block generalises the fixed 16-entry NCRD timeout logic in jbi_mout with the following additions:
- configurable ID width and age depth;
- single-cycle rotating-priority error selection;
- duplicate-start and orphan-completion detection;
- silent discard of timeouts when logging is disabled.

---
 rtl/jbi_trans_timeout_tracker.sv | 211 +++++++++++++++++++++
 tb/tb_jbi_trans_timeout_tracker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jbi_trans_timeout_tracker.sv
// Per-ID aging timers for outstanding JBus requests, driven by a shared tick.
// Timed-out IDs are reported through a one-entry, pop-acknowledged error port.
module jbi_trans_timeout_tracker #(
  parameter int ID_W   = 4,
  parameter int AGE_W  = 2,
  parameter int TICK_W = 32,
  localparam int NUM_ID = 2 ** ID_W
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              start_vld,
  input  logic [ID_W-1:0]   start_id,
  input  logic              done_vld,
  input  logic [ID_W-1:0]   done_id,
  input  logic [TICK_W-1:0] timeval,
  input  logic [AGE_W-1:0]  age_limit,
  input  logic              log_enb,
  output logic              err_vld,
  output logic [ID_W-1:0]   err_id,
  input  logic              err_pop,
  output logic              err_log,
  output logic [NUM_ID-1:0] busy_vec,
  output logic              dup_start_err,
  output logic              orphan_done_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } ent_st_e;

  ent_st_e          st_q  [NUM_ID];
  ent_st_e          st_d  [NUM_ID];
  logic [AGE_W-1:0] age_q [NUM_ID];
  logic [AGE_W-1:0] age_d [NUM_ID];

  logic [TICK_W-1:0] cntr_q, cntr_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   err_id_q, err_id_d;
  logic              err_vld_q, err_vld_d;
  logic              dup_q, dup_d;
  logic              orph_q, orph_d;

  logic              tick_s;
  logic [AGE_W:0]    lim_s;
  logic              found_s;
  logic [ID_W-1:0]   sel_id_s;
  logic              clr_en_s;
  logic [ID_W-1:0]   clr_id_s;
  logic [NUM_ID-1:0] start_hit_s;
  logic [NUM_ID-1:0] done_hit_s;

  // Status decode and output mapping
  always_comb begin
    for (int i = 0; i < NUM_ID; i++) begin
      busy_vec[i] = (st_q[i] != ST_IDLE);
    end
    err_vld         = err_vld_q;
    err_id          = err_id_q;
    err_log         = err_pop & err_vld_q;
    dup_start_err   = dup_q;
    orphan_done_err = orph_q;
  end

  // Shared tick counter; idles at zero while nothing is outstanding
  always_comb begin
    tick_s = (cntr_q >= timeval);
    if (tick_s || (busy_vec == '0)) begin
      cntr_d = '0;
    end else begin
      cntr_d = cntr_q + TICK_W'(1);
    end
  end

  // Effective age limit (0 behaves as 1)
  always_comb begin
    if (age_limit == '0) begin
      lim_s = (AGE_W+1)'(1);
    end else begin
      lim_s = {1'b0, age_limit};
    end
  end

  // Rotating-priority search for the first ERR entry at or after ptr
  always_comb begin
    logic [ID_W-1:0] idx_v;
    idx_v    = ptr_q;
    found_s  = 1'b0;
    sel_id_s = ptr_q;
    for (int i = 0; i < NUM_ID; i++) begin
      idx_v = ptr_q + ID_W'(i);
      if (!found_s && (st_q[idx_v] == ST_ERR)) begin
        found_s  = 1'b1;
        sel_id_s = idx_v;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Report port: register a report, pop it, or silently discard when logging is off
  always_comb begin
    err_vld_d = err_vld_q;
    err_id_d  = err_id_q;
    ptr_d     = ptr_q;
    clr_en_s  = 1'b0;
    clr_id_s  = err_id_q;
    if (err_vld_q) begin
      if (err_pop) begin
        err_vld_d = 1'b0;
        ptr_d     = err_id_q + ID_W'(1);
        clr_en_s  = 1'b1;
        clr_id_s  = err_id_q;
      end else begin
        err_vld_d = 1'b1;
      end
    end else if (found_s) begin
      if (log_enb) begin
        err_vld_d = 1'b1;
        err_id_d  = sel_id_s;
      end else begin
        clr_en_s  = 1'b1;
        clr_id_s  = sel_id_s;
        ptr_d     = sel_id_s + ID_W'(1);
      end
    end else begin
      err_vld_d = 1'b0;
    end
  end

  // Per-entry next state: done, then start, then tick or scrub clear
  always_comb begin
    dup_d  = 1'b0;
    orph_d = 1'b0;
    for (int i = 0; i < NUM_ID; i++) begin
      st_d[i]        = st_q[i];
      age_d[i]       = age_q[i];
      done_hit_s[i]  = done_vld  && (done_id  == ID_W'(i));
      start_hit_s[i] = start_vld && (start_id == ID_W'(i));
      if (done_hit_s[i]) begin
        if (st_q[i] == ST_IDLE) begin
          orph_d = 1'b1;
        end else begin
          orph_d = orph_d;
        end
        st_d[i]  = ST_IDLE;
        age_d[i] = '0;
      end else begin
        st_d[i] = st_d[i];
      end
      if (start_hit_s[i]) begin
        if ((st_q[i] != ST_IDLE) && !done_hit_s[i]) begin
          dup_d = 1'b1;
        end else begin
          dup_d = dup_d;
        end
        st_d[i]  = ST_RUN;
        age_d[i] = '0;
      end else begin
        st_d[i] = st_d[i];
      end
      if (!start_hit_s[i] && !done_hit_s[i]) begin
        if (clr_en_s && (clr_id_s == ID_W'(i)) && (st_q[i] == ST_ERR)) begin
          st_d[i]  = ST_IDLE;
          age_d[i] = '0;
        end else if (tick_s && (st_q[i] == ST_RUN)) begin
          if (({1'b0, age_q[i]} + (AGE_W+1)'(1)) >= lim_s) begin
            st_d[i] = ST_ERR;
          end else if (age_q[i] != {AGE_W{1'b1}}) begin
            age_d[i] = age_q[i] + AGE_W'(1);
          end else begin
            age_d[i] = age_q[i];
          end
        end else begin
          st_d[i] = st_q[i];
        end
      end else begin
        st_d[i] = st_d[i];
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cntr_q    <= '0;
      ptr_q     <= '0;
      err_id_q  <= '0;
      err_vld_q <= 1'b0;
      dup_q     <= 1'b0;
      orph_q    <= 1'b0;
      for (int i = 0; i < NUM_ID; i++) begin
        st_q[i]  <= ST_IDLE;
        age_q[i] <= '0;
      end
    end else begin
      cntr_q    <= cntr_d;
      ptr_q     <= ptr_d;
      err_id_q  <= err_id_d;
      err_vld_q <= err_vld_d;
      dup_q     <= dup_d;
      orph_q    <= orph_d;
      for (int i = 0; i < NUM_ID; i++) begin
        st_q[i]  <= st_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_jbi_trans_timeout_tracker.sv
// Directed bench for jbi_trans_timeout_tracker: a cycle table for the basic
// timeout/pop and dup/orphan flows, plus hand sequences for ordering and reset.
module tb_jbi_trans_timeout_tracker;
  localparam int ID_W   = 4;
  localparam int AGE_W  = 2;
  localparam int TICK_W = 32;
  localparam int NUM_ID = 16;

  logic              clk = 1'b0;
  logic              rst_l;
  logic              start_vld;
  logic [ID_W-1:0]   start_id;
  logic              done_vld;
  logic [ID_W-1:0]   done_id;
  logic [TICK_W-1:0] timeval;
  logic [AGE_W-1:0]  age_limit;
  logic              log_enb;
  logic              err_vld;
  logic [ID_W-1:0]   err_id;
  logic              err_pop;
  logic              err_log;
  logic [NUM_ID-1:0] busy_vec;
  logic              dup_start_err;
  logic              orphan_done_err;

  int checks = 0;
  int errors = 0;

  jbi_trans_timeout_tracker #(.ID_W(ID_W), .AGE_W(AGE_W), .TICK_W(TICK_W)) dut (
    .clk(clk), .rst_l(rst_l),
    .start_vld(start_vld), .start_id(start_id),
    .done_vld(done_vld), .done_id(done_id),
    .timeval(timeval), .age_limit(age_limit), .log_enb(log_enb),
    .err_vld(err_vld), .err_id(err_id), .err_pop(err_pop), .err_log(err_log),
    .busy_vec(busy_vec), .dup_start_err(dup_start_err), .orphan_done_err(orphan_done_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [3:0]  sid;
    logic        dv;
    logic [3:0]  did;
    logic        pop;
    logic        e_vld;
    logic [3:0]  e_id;
    logic [15:0] e_busy;
    logic        e_dup;
    logic        e_orph;
    logic        e_log;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic sv, input logic [3:0] sid, input logic dv,
                              input logic [3:0] did, input logic pop, input logic e_vld,
                              input logic [3:0] e_id, input logic [15:0] e_busy,
                              input logic e_dup, input logic e_orph, input logic e_log);
    vec_t v;
    v.sv = sv; v.sid = sid; v.dv = dv; v.did = did; v.pop = pop;
    v.e_vld = e_vld; v.e_id = e_id; v.e_busy = e_busy;
    v.e_dup = e_dup; v.e_orph = e_orph; v.e_log = e_log;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    start_vld = 1'b0; start_id = '0;
    done_vld  = 1'b0; done_id  = '0;
    err_pop   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  // Waits (bounded) until err_vld is seen at a negedge; expiry counts as a failure.
  task automatic wait_vld(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!err_vld && n < budget) begin
      step();
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, err_vld}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ord [2];
    bit seen;
    int n;

    rst_l = 1'b0; idle_in();
    timeval = 32'd3; age_limit = 2'd2; log_enb = 1'b1;
    #2;
    chk("reset_outputs", {8'd0, err_vld, err_id, busy_vec, dup_start_err, orphan_done_err, err_log},
        32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    step();

    // start 2 then done 2 before any timeout
    start_vld = 1'b1; start_id = 4'd2;
    step(); step(); step(); step();
    done_vld = 1'b1; done_id = 4'd2;
    step();
    @(negedge clk);
    chk("done_clears_busy", {15'd0, busy_vec, orphan_done_err}, 32'd0);
    step(); step();
    @(negedge clk);
    chk("done_no_error", {30'd0, err_vld, dup_start_err}, 32'd0);
    step();

    // Cycle table: id 5 timeout/pop, then dup/orphan/same-cycle restart on ids 7 and 8
    tbl[0] = mk(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++)
      tbl[i] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0020, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h0020, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h0020, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 16'h0020, 1'b0, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0080, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b0, 4'd0, 1'b1, 4'd8, 1'b0, 1'b0, 4'd0, 16'h0080, 1'b1, 1'b0, 1'b0);
    tbl[17] = mk(1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 16'h0080, 1'b0, 1'b1, 1'b0);
    tbl[18] = mk(1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 16'h0080, 1'b0, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[20] = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 21; i++) begin
      start_vld = tbl[i].sv; start_id = tbl[i].sid;
      done_vld  = tbl[i].dv; done_id  = tbl[i].did;
      err_pop   = tbl[i].pop;
      @(negedge clk);
      checks++;
      if ({err_vld, busy_vec, dup_start_err, orphan_done_err, err_log} !==
          {tbl[i].e_vld, tbl[i].e_busy, tbl[i].e_dup, tbl[i].e_orph, tbl[i].e_log}) begin
        errors++;
        $display("FAIL table_%0d actual vld=%0b busy=%h dup=%0b orph=%0b log=%0b required vld=%0b busy=%h dup=%0b orph=%0b log=%0b",
                 i, err_vld, busy_vec, dup_start_err, orphan_done_err, err_log,
                 tbl[i].e_vld, tbl[i].e_busy, tbl[i].e_dup, tbl[i].e_orph, tbl[i].e_log);
      end
      if (tbl[i].e_vld) chk($sformatf("table_%0d_err_id", i), {28'd0, err_id}, {28'd0, tbl[i].e_id});
      step();
    end

    // Move ptr to 10 by reporting and popping id 9
    start_vld = 1'b1; start_id = 4'd9;
    step();
    wait_vld("id9_vld", 40);
    chk("id9_err_id", {28'd0, err_id}, 32'd9);
    err_pop = 1'b1;
    step();
    @(negedge clk);
    chk("id9_popped", {15'd0, err_vld, busy_vec}, 32'd0);
    step();

    // ids 1, 14, 9 time out together; rotating order from ptr=10 is 14, 1, 9
    start_vld = 1'b1; start_id = 4'd1;  step();
    start_vld = 1'b1; start_id = 4'd14; step();
    start_vld = 1'b1; start_id = 4'd9;  step();
    wait_vld("order_first_vld", 40);
    chk("order_first_id", {28'd0, err_id}, 32'd14);
    ord[0] = 4'd1; ord[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      err_pop = 1'b1;
      step();
      @(negedge clk);
      chk($sformatf("order_bubble_%0d", k), {31'd0, err_vld}, 32'd0);
      step();
      @(negedge clk);
      chk($sformatf("order_vld_%0d", k), {31'd0, err_vld}, 32'd1);
      chk($sformatf("order_id_%0d", k), {28'd0, err_id}, {28'd0, ord[k]});
    end
    err_pop = 1'b1;
    step();
    @(negedge clk);
    chk("order_all_idle", {15'd0, err_vld, busy_vec}, 32'd0);
    step();

    // Logging disabled: ids 3 and 4 discarded on consecutive cycles
    log_enb = 1'b0;
    start_vld = 1'b1; start_id = 4'd3; step();
    start_vld = 1'b1; start_id = 4'd4; step();
    n = 0;
    @(negedge clk);
    while (busy_vec[3] && n < 40) begin
      step();
      @(negedge clk);
      n++;
    end
    chk("discard3_done", {31'd0, busy_vec[3]}, 32'd0);
    chk("discard4_pending", {30'd0, busy_vec[4], err_vld}, 32'd2);
    step();
    @(negedge clk);
    chk("discard4_done", {30'd0, busy_vec[4], err_vld}, 32'd0);
    log_enb = 1'b1;
    step();

    // Restart on a tick cycle resets the age: report moves from cycle 10 to 14
    start_vld = 1'b1; start_id = 4'd6;
    step(); step(); step(); step();
    start_vld = 1'b1; start_id = 4'd6;
    step();
    @(negedge clk);
    chk("tick_restart_dup", {31'd0, dup_start_err}, 32'd1);
    seen = 1'b0;
    for (int c = 5; c < 14; c++) begin
      if (c != 5) @(negedge clk);
      if (err_vld) seen = 1'b1;
      step();
    end
    chk("tick_restart_hold", {31'd0, seen}, 32'd0);
    @(negedge clk);
    chk("tick_restart_vld", {27'd0, err_vld, err_id}, {27'd0, 1'b1, 4'd6});
    err_pop = 1'b1;
    step();

    // Asynchronous reset while a report is pending
    start_vld = 1'b1; start_id = 4'd0;
    step();
    wait_vld("rst_pre_vld", 40);
    #1;
    rst_l = 1'b0;
    #1;
    chk("async_reset", {8'd0, err_vld, err_id, busy_vec, dup_start_err, orphan_done_err, err_log},
        32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    step();
    @(negedge clk);
    chk("post_reset", {15'd0, err_vld, busy_vec}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
